// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command sequencer.
package uart_pkg;

    // Start bit, eight data bits and a stop bit make one character
    localparam int UART_FRAME_BITS      = 10;
    // 50 MHz clock divided down to 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default twelve-byte command frame; byte 0 is transmitted first
    typedef logic [11:0][7:0] cmd_frame_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Bit-level 8N1 serializer: start bit, d[0]..d[7], stop bit, CLKS_PER_BIT clocks each.
//
// Handshake: a byte is accepted on any clock edge where valid & ready are both
// high; data must be stable in that cycle. ready is high while idle, and also
// during the final cycle of the stop bit. This lets the next start bit follow
// the stop bit directly. If nothing is offered then, the serializer goes idle.
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    logic              active;
    logic [8:0]        shreg;     // remaining bits after the start bit: data then stop
    logic [3:0]        bit_cnt;   // 0 = start bit, 1..8 = data, 9 = stop bit
    logic [BAUD_W-1:0] baud_cnt;
    logic              last_tick;

    assign last_tick = active && (bit_cnt == 4'(UART_FRAME_BITS - 1))
                              && (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign ready     = ~active | last_tick;

    // Load on handshake, otherwise step through the bit cells of the character
    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            tx       <= 1'b1;
            shreg    <= '1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (valid && ready) begin
            active   <= 1'b1;
            tx       <= 1'b0;
            shreg    <= {1'b1, data};
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else if (active) begin
            if (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1)) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'(UART_FRAME_BITS - 1)) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx      <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Sends a captured NUM_BYTES command frame as back-to-back 8N1 characters.
module uart_cmd_sequencer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_BYTES    = 12,
    parameter int GAP_CLKS     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_start,
    input  logic [NUM_BYTES-1:0][7:0] cmd_buf,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    state_t                    state;    // visible to checkers by hierarchical name
    logic                      start_q;
    logic                      trig;
    logic [NUM_BYTES-1:0][7:0] frame;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_next;
    logic                      last_byte;
    logic [GAP_W-1:0]          gap_cnt;
    logic                      ser_valid;
    logic                      ser_ready;
    logic [7:0]                ser_data;

    assign trig      = uart_start & ~start_q;
    assign idx_next  = idx + IDX_W'(1);
    assign last_byte = (idx == IDX_W'(NUM_BYTES - 1));

    // Offer a byte to the serializer in the same cycle the FSM decides to send,
    // so the start bit appears one clock after the deciding edge
    always_comb begin
        ser_valid = 1'b0;
        ser_data  = frame[idx];
        case (state)
            IDLE: if (trig) begin
                ser_valid = 1'b1;
                ser_data  = cmd_buf[0];
            end
            SEND: if (ser_ready && !last_byte && (GAP_CLKS == 0)) begin
                ser_valid = 1'b1;
                ser_data  = frame[idx_next];
            end
            GAP:  if (gap_cnt == GAP_W'(GAP_CLKS - 1)) ser_valid = 1'b1;
            default: ser_valid = 1'b0;
        endcase
    end

    // Frame sequencer: edge detect, capture, byte ordering, gap and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx     <= '0;
            gap_cnt <= '0;
            frame   <= '0;
        end else begin
            start_q <= uart_start;
            done    <= 1'b0;
            case (state)
                IDLE: if (trig) begin
                    frame <= cmd_buf;
                    busy  <= 1'b1;
                    idx   <= '0;
                    state <= SEND;
                end
                SEND: if (ser_ready) begin
                    if (last_byte) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx_next;
                        if (GAP_CLKS > 0) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CLKS - 1)) state <= SEND;
                    else gap_cnt <= gap_cnt + GAP_W'(1);
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk  (clk),
        .rst  (rst),
        .data (ser_data),
        .valid(ser_valid),
        .ready(ser_ready),
        .tx   (tx)
    );

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed-plus-random bench for uart_cmd_sequencer; the expected tx waveform is
// built bit by bit from the 8N1 framing rules and compared cycle by cycle.
module tb_uart_cmd_sequencer;

    localparam int CPB = 4;
    localparam int NB  = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start0, start1;
    logic [NB-1:0][7:0]   buf0, buf1;
    logic                 tx0, busy0, done0;
    logic                 tx1, busy1, done1;

    logic [0:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    uart_cmd_sequencer #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .GAP_CLKS(0)) u_dut0 (
        .clk(clk), .rst(rst), .uart_start(start0), .cmd_buf(buf0),
        .tx(tx0), .busy(busy0), .done(done0)
    );

    uart_cmd_sequencer #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB), .GAP_CLKS(3)) u_dut1 (
        .clk(clk), .rst(rst), .uart_start(start1), .cmd_buf(buf1),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    // driver / accessor helpers
    function automatic logic get_tx(input int d);   return (d == 1) ? tx1 : tx0;     endfunction
    function automatic logic get_busy(input int d); return (d == 1) ? busy1 : busy0; endfunction
    function automatic logic get_done(input int d); return (d == 1) ? done1 : done0; endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 1) start1 = v; else start0 = v;
    endtask

    task automatic set_buf(input int d, input logic [NB-1:0][7:0] v);
        if (d == 1) buf1 = v; else buf0 = v;
    endtask

    function automatic logic [NB-1:0][7:0] rand_frame();
        logic [NB-1:0][7:0] f;
        for (int i = 0; i < NB; i++) f[i] = 8'($urandom_range(0, 255));
        return f;
    endfunction

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: build the expected line waveform for one frame
    task automatic build_expect(input logic [NB-1:0][7:0] bytes, input int gap);
        logic [7:0] b;
        exp_q.delete();
        for (int k = 0; k < NB; k++) begin
            b = bytes[k];
            for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++)
                for (int c = 0; c < CPB; c++) exp_q.push_back(b[i]);
            for (int c = 0; c < CPB; c++) exp_q.push_back(1'b1);
            if (k < NB - 1)
                for (int c = 0; c < gap; c++) exp_q.push_back(1'b1);
        end
    endtask

    // Called at a negedge with the triggering inputs already applied: the next
    // posedge is the trig edge, so the first cycle after it must carry the start bit.
    // Returns at the negedge of the cycle where done should be high.
    task automatic run_frame(input int d, input logic [NB-1:0][7:0] bytes, input int gap,
                             input int fall_at, input int rise_at,
                             input logic [NB-1:0][7:0] new_bytes, input string tag);
        int n, errs, busy_cnt, done_seen;
        build_expect(bytes, gap);
        n = exp_q.size();
        errs = 0; busy_cnt = 0; done_seen = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (get_tx(d) !== exp_q[c]) errs++;
            if (get_busy(d) === 1'b1) busy_cnt++;
            if (get_done(d) === 1'b1) done_seen++;
            if (c == fall_at) set_start(d, 1'b0);
            if (c == rise_at) begin
                set_start(d, 1'b1);
                set_buf(d, new_bytes);
            end
        end
        check({tag, "_wave_errs"}, errs, 0);
        check({tag, "_busy_cycles"}, busy_cnt, n);
        check({tag, "_early_done"}, done_seen, 0);
        @(negedge clk);
        check({tag, "_done"}, int'(get_done(d)), 1);
        check({tag, "_busy_at_done"}, int'(get_busy(d)), 0);
        check({tag, "_tx_at_done"}, int'(get_tx(d)), 1);
    endtask

    logic [NB-1:0][7:0] fa, fb, fr;
    logic [NB-1:0][7:0] none_f;
    int cnt;

    initial begin
        none_f = '0;
        // byte 0 first: 30,24,00,B0,5E,00,00,00,00,00,07,00
        fa = '0;
        fa[0] = 8'h30; fa[1] = 8'h24; fa[3] = 8'hB0; fa[4] = 8'h5E; fa[10] = 8'h07;

        rst = 1'b1; start0 = 1'b1; start1 = 1'b0; buf0 = fa; buf1 = '0;
        repeat (3) @(negedge clk);
        check("rst_tx0", int'(tx0), 1);
        check("rst_busy0", int'(busy0), 0);
        check("rst_done0", int'(done0), 0);
        check("rst_tx1", int'(tx1), 1);

        // start held high through reset release gives exactly one frame
        rst = 1'b0;
        run_frame(0, fa, 0, -1, -1, none_f, "held");
        @(negedge clk);
        check("done_width", int'(done0), 0);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || tx0 !== 1'b1 || done0 !== 1'b0) cnt++;
        end
        check("no_refire_held", cnt, 0);

        // edge while busy is dropped; cmd_buf change does not touch the frame in flight
        start0 = 1'b0;
        @(negedge clk);
        fa = rand_frame(); fb = rand_frame();
        buf0 = fa; start0 = 1'b1;
        run_frame(0, fa, 0, 90, 100, fb, "midedge");
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || tx0 !== 1'b1) cnt++;
        end
        check("dropped_edge_idle", cnt, 0);

        // fresh edge after done sends the new bytes
        start0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        run_frame(0, fb, 0, 5, -1, none_f, "second");

        // edge landing in the DONE cycle is ignored
        start0 = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy0 !== 1'b0 || tx0 !== 1'b1) cnt++;
        end
        check("done_cycle_edge_ignored", cnt, 0);

        // edge one cycle after DONE is accepted
        start0 = 1'b0;
        @(negedge clk);
        fa = rand_frame(); buf0 = fa; start0 = 1'b1;
        run_frame(0, fa, 0, 5, -1, none_f, "pre_after_done");
        @(negedge clk);
        fb = rand_frame(); buf0 = fb; start0 = 1'b1;
        run_frame(0, fb, 0, 5, -1, none_f, "after_done");

        // reset during byte 5 abandons the frame without done
        @(negedge clk);
        fr = rand_frame(); buf0 = fr; start0 = 1'b1;
        for (int c = 0; c < 210; c++) begin
            @(negedge clk);
            if (c == 5) start0 = 1'b0;
        end
        check("busy_before_rst", int'(busy0), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", int'(tx0), 1);
        check("rst_mid_busy", int'(busy0), 0);
        check("rst_mid_done", int'(done0), 0);
        rst = 1'b0;
        cnt = 0;
        repeat (500) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0 || tx0 !== 1'b1) cnt++;
        end
        check("rst_mid_quiet", cnt, 0);
        fr = rand_frame(); buf0 = fr; start0 = 1'b1;
        run_frame(0, fr, 0, 5, -1, none_f, "post_rst");

        // three idle cycles between characters
        @(negedge clk);
        fa = rand_frame(); buf1 = fa; start1 = 1'b1;
        run_frame(1, fa, 3, 5, -1, none_f, "gap3");
        @(negedge clk);
        check("gap3_done_width", int'(done1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
